// File: rtl/fetch_decode.sv
// fetch_decode: fetches, decodes and issues one instruction at a time to exec, owning pc and the int/float register files
module fetch_decode #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [63:0] XSRC_MASK = 64'h0,
  parameter logic [63:0] XSRT_MASK = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        exec_enable,
  output logic [5:0]  opecode,
  output logic [4:0]  rd_no,
  output logic [4:0]  rs_no,
  output logic [4:0]  rt_no,
  output logic [15:0] offset,
  output logic [31:0] pc,
  output logic [31:0] rs,
  output logic [31:0] rt,
  output logic        fmode1,
  output logic        fmode2,
  input  logic        done,
  input  logic        stop,
  input  logic        pcenable,
  input  logic [31:0] next_pc,
  input  logic        wenable,
  input  logic        wfmode,
  input  logic [4:0]  wreg,
  input  logic [31:0] wdata,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {PRIME, FETCH, DECODE, ISSUE, RETRY, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] xr [32];
  logic [31:0] fr [32];
  logic [31:0] ir, hold_rs, hold_rt, rs_rd, rt_rd;
  logic [5:0] clr;
  logic prime, retire, f1, f2;
  always_comb begin
    state_n = state;
    retire = 1'b0;
    case (state)
      PRIME: state_n = clr[5] ? FETCH : PRIME;
      FETCH: state_n = DECODE;
      DECODE: state_n = ISSUE;
      ISSUE: begin
        retire = !stop && done;
        state_n = stop ? RETRY : done ? FETCH : WAIT;
      end
      RETRY: state_n = ISSUE;
      WAIT: begin
        retire = done;
        state_n = done ? FETCH : WAIT;
      end
      default: state_n = PRIME;
    endcase
  end
  always_comb begin
    f1 = ir[31] ^ XSRC_MASK[ir[31:26]];
    f2 = ir[31] ^ XSRT_MASK[ir[31:26]];
    rs_rd = (!f1 && ir[20:16] == 5'd0) ? 32'd0 :
            (wenable && wfmode == f1 && wreg == ir[20:16]) ? wdata :
            f1 ? fr[ir[20:16]] : xr[ir[20:16]];
    rt_rd = (!f2 && ir[15:11] == 5'd0) ? 32'd0 :
            (wenable && wfmode == f2 && wreg == ir[15:11]) ? wdata :
            f2 ? fr[ir[15:11]] : xr[ir[15:11]];
    prime = state == PRIME && clr[5];
    exec_enable = prime || state == ISSUE;
    imem_addr = state == FETCH ? pc[20:2] : 19'd0;
    opecode = prime ? 6'h02 : ir[31:26];
    rd_no = ir[25:21];
    rs_no = ir[20:16];
    rt_no = ir[15:11];
    offset = ir[15:0];
    fmode1 = state != PRIME && f1;
    fmode2 = state != PRIME && f2;
    rs = state == ISSUE ? rs_rd : hold_rs;
    rt = state == ISSUE ? rt_rd : hold_rt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
      pc <= RESET_PC;
      retired <= 32'd0;
      ir <= 32'd0;
      hold_rs <= 32'd0;
      hold_rt <= 32'd0;
      clr <= 6'd0;
    end else begin
      state <= state_n;
      if (!clr[5]) clr <= clr + 6'd1;
      if (state == DECODE) ir <= imem_rdata;
      if (state == ISSUE) begin
        hold_rs <= rs_rd;
        hold_rt <= rt_rd;
      end
      if (retire) begin
        pc <= pcenable ? next_pc : pc + 32'd4;
        retired <= retired + 32'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || !clr[5]) begin
      xr[clr[4:0]] <= 32'd0;
      fr[clr[4:0]] <= 32'd0;
    end
    if (wenable && !rst) begin
      if (wfmode) fr[wreg] <= wdata;
      else xr[wreg] <= wdata;
    end
  end
endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Upstream stage of exec_inner: fetches instruction words from instruction BRAM, decodes fields, reads integer/float register files and presents one instruction at a time to exec.
- Owns the PC and both 32x32 register files; consumes exec's write-back port (wenable/wfmode/wreg/wdata) and its redirect (pcenable/next_pc).
- Issue policy is strictly one outstanding instruction: issue, wait for done, then fetch the next.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- XSRC_MASK, 64'h0, bit i set: opcode i reads rs from the opposite file (fmode1 = ~opecode[5]).
- XSRT_MASK, 64'h0, bit i set: opcode i reads rt from the opposite file (fmode2 = ~opecode[5]).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  19  word address (pc[20:2]).
- imem_rdata  in  32  instruction word, valid 1 cycle after imem_addr.
- exec_enable  out  1  one-cycle issue strobe to exec.
- opecode  out  6  inst[31:26].
- rd_no  out  5  inst[25:21].
- rs_no  out  5  inst[20:16].
- rt_no  out  5  inst[15:11].
- offset  out  16  inst[15:0].
- pc  out  32  address of the issued instruction.
- rs  out  32  source 1 value.
- rt  out  32  source 2 value.
- fmode1  out  1  source 1 file select.
- fmode2  out  1  source 2 file select.
- done  in  1  exec retire pulse.
- stop  in  1  exec reject, combinational, valid during exec_enable.
- pcenable  in  1  exec: next_pc is a taken redirect.
- next_pc  in  32  exec redirect target.
- wenable  in  1  write-back strobe.
- wfmode  in  1  write-back file: 1 = float.
- wreg  in  5  write-back register.
- wdata  in  32  write-back data.
- retired  out  32  count of retired instructions.

Behaviour:
- Reset, synchronous on rst=1:
  - pc <= RESET_PC; state <= PRIME; all outputs 0; retired <= 0.
  - Register files zeroed. Zeroing may take 32 cycles via a clear counter; PRIME waits for it to finish.
- Register files:
  - Integer r0 reads 0 and ignores writes. Float f0 is an ordinary register.
  - Write on wenable at the clock edge.
  - Read bypass: a read in the same cycle as a write to the same (file, index) returns wdata.
- fmode1 = opecode[5] ^ XSRC_MASK[opecode]; fmode2 = opecode[5] ^ XSRT_MASK[opecode].
- States:
  - PRIME: exec_enable=1 for one cycle with opecode=6'h02 (J) and all other fields 0. Exec discards its first issue after reset; the done it returns is ignored and not counted. Next state FETCH.
  - FETCH: drive imem_addr=pc[20:2]. Next state DECODE.
  - DECODE: latch imem_rdata into the instruction register. Next state ISSUE.
  - ISSUE:
    - exec_enable=1; fields, rs and rt are driven from the latched instruction.
    - rs/rt are read from the register file combinationally that cycle, bypass included.
    - stop=1: the attempt is void. Next state RETRY, with no count and no PC change.
    - stop=0: next state WAIT.
  - RETRY: exec_enable=0 for one cycle; done is ignored. Next state ISSUE with the same instruction word, which is not refetched.
  - WAIT:
    - Hold all outputs stable; exec_enable=0.
    - On done: pc <= pcenable ? next_pc : pc+4; retired <= retired+1; next state FETCH.
    - done in the same cycle as exec_enable counts as retire of the issued instruction. Exec asserts done in the cycle after enable for single-cycle ops; later for FDIV, SQRT and UART ops.
- Latency: 4 cycles per single-cycle instruction (FETCH, DECODE, ISSUE, WAIT with done).
- pcenable is sampled only on the done cycle. Exec holds pcenable until its next enable.
- PC arithmetic is 32-bit wrap-around. imem_addr uses pc[20:2]; pc[1:0] and pc[31:21] are not range-checked.
- retired wraps from 32'hFFFFFFFF to 0.
- A write-back (wenable) may arrive in any state and is always applied.
- rst in any state aborts the current instruction immediately. No done is expected afterwards.

Test Plan:
- Reset, then program ADDI r1,r0,5 at 0x0 -> exactly one PRIME strobe with opecode=J; issue at pc=0 shows rs_no=0 and rs=0; the following done gives pc=4 and retired=1.
- Write-back wenable=1, wfmode=0, wreg=3, wdata=32'hDEADBEEF in the same cycle as an ISSUE reading rs_no=3 -> rs=32'hDEADBEEF (bypass). The same write with wreg=0 -> a later read of r0 returns 0.
- Float write wfmode=1, wreg=0, wdata=32'h3F800000; then an instruction with opecode[5]=1 and rs_no=0 -> fmode1=1, rs=32'h3F800000.
- At pc=0x10, done with pcenable=1 and next_pc=32'h40 -> next imem_addr=19'h10 (word 0x40). The same with pcenable=0 -> imem_addr=19'h5.
- stop=1 during ISSUE -> one RETRY cycle with exec_enable=0, then re-issue with an identical instruction and no new imem_addr; retired is unchanged until a later done.
- Delayed done (17 cycles after issue, FDIV-like) -> outputs held stable throughout and exactly one retire; opcode set in XSRC_MASK -> fmode1 inverted.
